// File: rtl/div_pkg.sv
// Shared types for the signed divide controller: FSM state encoding and
// response status codes.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIXUP = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIV0    = 2'b01;
  localparam logic [1:0] ST_OVF     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; doubles as |x| on the way in and as
// the sign restore on the way out. The most negative value maps to itself.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/signed_div_ctrl.sv
// Signed/unsigned front/back end for a multi-cycle unsigned divider: operand
// magnitudes out, sign fix-up on return, divide-by-zero/overflow/timeout local.
module signed_div_ctrl
  import div_pkg::*;
#(
  parameter int SIZE_DATA      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_signed,
  input  logic [SIZE_DATA-1:0] i_req_dividend,
  input  logic [SIZE_DATA-1:0] i_req_divisor,
  output logic                 o_div_en,
  output logic [SIZE_DATA-1:0] o_div_dividend,
  output logic [SIZE_DATA-1:0] o_div_divisor,
  input  logic [SIZE_DATA-1:0] i_div_quotient,
  input  logic [SIZE_DATA-1:0] i_div_remainder,
  input  logic                 i_div_valid,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [SIZE_DATA-1:0] o_quotient,
  output logic [SIZE_DATA-1:0] o_remainder,
  output logic [1:0]           o_status
);

  localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SIZE_DATA-1:0] MIN_VAL  = {1'b1, {(SIZE_DATA-1){1'b0}}};

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [SIZE_DATA-1:0] q_cap;
  logic [SIZE_DATA-1:0] r_cap;
  logic                 dividend_neg;
  logic                 divisor_neg;

  logic [SIZE_DATA-1:0] fix_a_in;
  logic [SIZE_DATA-1:0] fix_b_in;
  logic [SIZE_DATA-1:0] fix_a_out;
  logic [SIZE_DATA-1:0] fix_b_out;
  logic                 fix_a_neg;
  logic                 fix_b_neg;

  assign o_req_ready = (state == IDLE);
  assign o_div_en    = (state == ISSUE);
  assign o_rsp_valid = (state == RESP);

  // The two negators are shared: request operands while idle, captured
  // divider results during FIXUP.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fix_a_in  = i_req_dividend;
    fix_b_in  = i_req_divisor;
    fix_a_neg = i_req_signed & i_req_dividend[SIZE_DATA-1];
    fix_b_neg = i_req_signed & i_req_divisor[SIZE_DATA-1];
    if (state == FIXUP) begin
      fix_a_in  = q_cap;
      fix_b_in  = r_cap;
      fix_a_neg = dividend_neg ^ divisor_neg;
      fix_b_neg = dividend_neg;
    end
  end

  div_sign_fix #(.WIDTH(SIZE_DATA)) u_fix_a (
    .value  (fix_a_in),
    .negate (fix_a_neg),
    .result (fix_a_out)
  );

  div_sign_fix #(.WIDTH(SIZE_DATA)) u_fix_b (
    .value  (fix_b_in),
    .negate (fix_b_neg),
    .result (fix_b_out)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    if (!i_rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      q_cap          <= '0;
      r_cap          <= '0;
      dividend_neg   <= 1'b0;
      divisor_neg    <= 1'b0;
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
      o_quotient     <= '0;
      o_remainder    <= '0;
      o_status       <= ST_OK;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            dividend_neg <= fix_a_neg;
            divisor_neg  <= fix_b_neg;
            if (i_req_divisor == '0) begin
              o_quotient  <= '1;
              o_remainder <= i_req_dividend;
              o_status    <= ST_DIV0;
              state       <= RESP;
            end else if (i_req_signed && (i_req_dividend == MIN_VAL) &&
                         (i_req_divisor == '1)) begin
              o_quotient  <= MIN_VAL;
              o_remainder <= '0;
              o_status    <= ST_OVF;
              state       <= RESP;
            end else begin
              o_div_dividend <= fix_a_out;
              o_div_divisor  <= fix_b_out;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still wins over the timeout.
          if (i_div_valid) begin
            q_cap <= i_div_quotient;
            r_cap <= i_div_remainder;
            state <= FIXUP;
          end else if (wait_cnt == CNT_LAST) begin
            o_quotient  <= '0;
            o_remainder <= '0;
            o_status    <= ST_TIMEOUT;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        FIXUP: begin
          o_quotient  <= fix_a_out;
          o_remainder <= fix_b_out;
          o_status    <= ST_OK;
          state       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_ctrl.sv
// Directed bench for signed_div_ctrl with a behavioural divider of
// programmable latency and hand-computed expected results.
module tb_signed_div_ctrl;
  import div_pkg::*;

  localparam int W  = 32;
  localparam int TO = 256;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_req_valid;
  logic         o_req_ready;
  logic         i_req_signed;
  logic [W-1:0] i_req_dividend;
  logic [W-1:0] i_req_divisor;
  logic         o_div_en;
  logic [W-1:0] o_div_dividend;
  logic [W-1:0] o_div_divisor;
  logic [W-1:0] i_div_quotient;
  logic [W-1:0] i_div_remainder;
  logic         i_div_valid;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic [1:0]   o_status;

  always #5 clk = ~clk;

  signed_div_ctrl #(.SIZE_DATA(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_signed    (i_req_signed),
    .i_req_dividend  (i_req_dividend),
    .i_req_divisor   (i_req_divisor),
    .o_div_en        (o_div_en),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder),
    .i_div_valid     (i_div_valid),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_quotient      (o_quotient),
    .o_remainder     (o_remainder),
    .o_status        (o_status)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Divider model: result pulse arrives 'lat' cycles after the o_div_en cycle.
  int           lat         = 3;
  bit           mute        = 1'b0;
  int           inject_req  = 0;
  int           inject_done = 0;
  int           busy_cnt    = 0;
  int           en_seen     = 0;
  logic [W-1:0] seen_a      = '0;
  logic [W-1:0] seen_b      = '1;

  initial begin
    i_div_valid     = 1'b0;
    i_div_quotient  = '0;
    i_div_remainder = '0;
  end

  always @(negedge clk) begin
    i_div_valid = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0 && !mute) begin
        i_div_valid     = 1'b1;
        i_div_quotient  = seen_a / seen_b;
        i_div_remainder = seen_a % seen_b;
      end
    end
    if (inject_req != inject_done) begin
      i_div_valid     = 1'b1;
      i_div_quotient  = 32'h55;
      i_div_remainder = 32'h66;
      inject_done++;
    end
    if (o_div_en) begin
      en_seen++;
      busy_cnt = lat;
      seen_a   = o_div_dividend;
      seen_b   = o_div_divisor;
    end
  end

  task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic [1:0] est,
                       input int elat, input int een, input int hold);
    int   cyc;
    int   en0;
    logic ok;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    en0            = en_seen;
    i_req_valid    = 1'b1;
    i_req_signed   = sgn;
    i_req_dividend = a;
    i_req_divisor  = b;
    @(negedge clk);
    i_req_valid = 1'b0;
    cyc = 1;
    while (!o_rsp_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(elat));
    check({tag, "_q"}, o_quotient, eq);
    check({tag, "_r"}, o_remainder, er);
    check({tag, "_status"}, 32'(o_status), 32'(est));
    check({tag, "_div_en_cycles"}, 32'(en_seen - en0), 32'(een));
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!o_rsp_valid || o_req_ready || o_quotient !== eq ||
            o_remainder !== er || o_status !== est) ok = 1'b0;
      end
      check({tag, "_hold_stable"}, 32'(ok), 32'd1);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check({tag, "_done"}, 32'({o_rsp_valid, o_req_ready}), 32'b01);
  endtask

  initial begin
    logic ok;
    i_rst_n        = 1'b0;
    i_req_valid    = 1'b0;
    i_req_signed   = 1'b0;
    i_req_dividend = '0;
    i_req_divisor  = '0;
    i_rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_div_en", 32'(o_div_en), 32'd0);
    check("rst_q", o_quotient, 32'd0);
    check("rst_r", o_remainder, 32'd0);
    check("rst_status", 32'(o_status), 32'd0);
    check("rst_div_dividend", o_div_dividend, 32'd0);
    i_rst_n = 1'b1;

    lat = 3;
    do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, ST_OK, 6, 1, 0);
    check("u100_7_div_a", seen_a, 32'd100);
    check("u100_7_div_b", seen_b, 32'd7);

    lat = 1;
    do_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, ST_OK, 4, 1, 0);
    check("sm7_2_div_a", seen_a, 32'd7);
    lat = 5;
    do_op("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, ST_OK, 8, 1, 0);
    check("s7_m2_div_a", seen_a, 32'd7);
    check("s7_m2_div_b", seen_b, 32'd2);
    do_op("sm7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, ST_OK, 8, 1, 0);
    do_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, ST_OK, 8, 1, 0);

    do_op("s_div0", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, ST_DIV0, 1, 0, 0);
    do_op("u_div0", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, ST_DIV0, 1, 0, 0);

    do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, ST_OVF, 1, 0, 0);
    do_op("u_min_ones", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, ST_OK, 8, 1, 0);
    check("u_min_ones_div_a", seen_a, 32'h8000_0000);
    check("u_min_ones_div_b", seen_b, 32'hFFFF_FFFF);
    do_op("s_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, ST_OK, 8, 1, 0);
    check("s_min_1_div_a", seen_a, 32'h8000_0000);

    // Divider silent: WAIT lasts TO cycles after the ISSUE cycle.
    mute = 1'b1;
    do_op("timeout", 1'b0, 32'd9, 32'd3, 32'd0, 32'd0, ST_TIMEOUT, TO + 2, 1, 0);
    inject_req++;
    repeat (3) @(negedge clk);
    check("late_valid_ignored", 32'({o_rsp_valid, o_req_ready}), 32'b01);
    mute = 1'b0;
    do_op("after_timeout", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, ST_OK, 8, 1, 0);

    do_op("rsp_hold", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, ST_OK, 8, 1, 10);

    // Reset while the divider is still working: op abandoned, no response.
    lat = 20;
    @(negedge clk);
    i_req_valid    = 1'b1;
    i_req_signed   = 1'b0;
    i_req_dividend = 32'd40;
    i_req_divisor  = 32'd4;
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    check("midrst_req_ready", 32'(o_req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("midrst_q", o_quotient, 32'd0);
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (o_rsp_valid || !o_req_ready) ok = 1'b0;
    end
    check("midrst_no_rsp", 32'(ok), 32'd1);
    lat = 2;
    do_op("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, ST_OK, 5, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
